sprite_rom_arbiter: RTL and testbench

Shares the single read port of the 320-pixel-wide sprite ROM among several sprite address requesters: player tanks, enemy tanks, explosions and HUD digits. Grants one read per cycle by round-robin, drives the ROM address, and routes the returned pixel data back to the requester that issued it. A frame-sync drain keeps reads from one frame from leaking into the next. Sits between the per-object address generators and the sprite ROM instance, upstream of the colour mapper.

---
 rtl/sprite_rom_arbiter_pkg.sv | 20 ++
 rtl/sprite_rom_arbiter_rr_pick.sv | 40 ++++
 rtl/sprite_rom_arbiter.sv | 127 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_rom_arbiter_pkg.sv
// ============================================================================
// sprite_rom_arbiter_pkg : shared constants and state type for sprite ROM arbitration
// Rev 1.0
// ============================================================================
`default_nettype none

package sprite_rom_arbiter_pkg;

    localparam int ROM_WIDTH  = 320;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first set bit at or above ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0] w_pos;

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps the search inside 0..N-1 for non power-of-2 N
            w_pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(N)) begin
                w_pos = w_pos - (IDX_W+1)'(N);
            end
            if (!any && req[w_pos[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = w_pos[IDX_W-1:0];
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// sprite_rom_arbiter : round-robin share of the sprite ROM read port with tagged return
// Rev 1.0
// ============================================================================
`default_nettype none

module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_sync,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic                    rom_rd,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_DEPTH = 1 + ROM_LAT;
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_DEPTH);

    arb_state_t                       r_state, w_state_nxt;
    logic [c_CNT_W-1:0]               r_cnt, w_cnt_nxt;
    logic [c_IDX_W-1:0]               r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]                 w_pick_gnt;
    logic [c_IDX_W-1:0]               w_pick_idx;
    logic                             w_pick_any;
    logic                             w_accept;
    logic [ADDR_W-1:0]                w_sel_addr;
    logic [c_DEPTH-1:0]               r_tag_v;
    logic [c_DEPTH-1:0][c_IDX_W-1:0]  r_tag_idx;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_sel_addr = req_addr[w_pick_idx*ADDR_W +: ADDR_W];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_accept    = 1'b0;
        gnt         = '0;
        case (r_state)
            RUN: begin
                // A same-cycle frame_sync does not block the grant
                w_accept = w_pick_any;
                gnt      = w_pick_gnt;
                if (w_pick_any) begin
                    w_ptr_nxt = (w_pick_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                end
                if (frame_sync) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            DRAIN: begin
                if (frame_sync) begin
                    w_cnt_nxt = c_CNT_LOAD;
                end else if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Tag pipeline is never flushed so reads issued before DRAIN still return
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr  <= '0;
            rom_rd    <= 1'b0;
            r_tag_v   <= '0;
            r_tag_idx <= '0;
        end else begin
            rom_rd <= w_accept;
            if (w_accept) begin
                rom_addr <= w_sel_addr;
            end
            r_tag_v   <= {r_tag_v[c_DEPTH-2:0], w_accept};
            r_tag_idx <= {r_tag_idx[c_DEPTH-2:0], w_pick_idx};
        end
    end

    assign rsp_valid = r_tag_v[ROM_LAT] ? (N_REQ'(1) << r_tag_idx[ROM_LAT]) : '0;
    assign rsp_data  = rom_data;
    assign busy      = (r_state == DRAIN) | (|r_tag_v);

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ============================================================================
// tb_sprite_rom_arbiter : vector table plus response scoreboard for sprite_rom_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sprite_rom_arbiter;

    localparam int AW = 20;
    localparam int DW = 8;

    localparam logic [AW-1:0] A0 = 20'h00100;
    localparam logic [AW-1:0] A1 = 20'd49635;
    localparam logic [AW-1:0] A2 = 20'h0ABCD;
    localparam logic [AW-1:0] A3 = 20'hFFFFF;
    localparam logic [AW-1:0] B0 = 20'h12345;
    localparam logic [AW-1:0] B1 = 20'h0F0F0;
    localparam logic [AW-1:0] B2 = 20'h00333;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            Reset;
    logic            frame_sync;
    logic [3:0]      req;
    logic [4*AW-1:0] req_addr;
    logic [3:0]      gnt;
    logic [AW-1:0]   rom_addr;
    logic            rom_rd;
    logic [DW-1:0]   rom_data;
    logic [3:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    logic [2:0]      req3;
    logic [3*AW-1:0] req_addr3;
    logic [2:0]      gnt3;
    logic [AW-1:0]   rom_addr3;
    logic            rom_rd3;
    logic [DW-1:0]   rom_data3;
    logic [2:0]      rsp_valid3;
    logic [DW-1:0]   rsp_data3;
    logic            busy3;
    logic            fs3;

    sprite_rom_arbiter dut (
        .Clk        (clk),
        .Reset      (Reset),
        .frame_sync (frame_sync),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    sprite_rom_arbiter #(.N_REQ(3)) dut3 (
        .Clk        (clk),
        .Reset      (Reset),
        .frame_sync (fs3),
        .req        (req3),
        .req_addr   (req_addr3),
        .gnt        (gnt3),
        .rom_addr   (rom_addr3),
        .rom_rd     (rom_rd3),
        .rom_data   (rom_data3),
        .rsp_valid  (rsp_valid3),
        .rsp_data   (rsp_data3),
        .busy       (busy3)
    );

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
    endfunction

    // Two-stage ROM model: data for the registered address appears two cycles later
    logic [DW-1:0] rp0, rp1, rq0, rq1;
    always @(posedge clk) begin
        rp0 <= romf(rom_addr);
        rp1 <= rp0;
        rq0 <= romf(rom_addr3);
        rq1 <= rq0;
    end
    assign rom_data  = rp1;
    assign rom_data3 = rq1;

    function automatic logic [AW-1:0] addr_of(input logic [3:0] oh);
        case (oh)
            4'b0001: return A0;
            4'b0010: return A1;
            4'b0100: return A2;
            default: return A3;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr3_of(input logic [2:0] oh);
        case (oh)
            3'b001:  return B0;
            3'b010:  return B1;
            default: return B2;
        endcase
    endfunction

    typedef struct {
        logic          fs;
        logic [3:0]    rq;
        logic [3:0]    g;
        logic          rd;
        logic [AW-1:0] ra;
        logic          bz;
    } vec_t;

    typedef struct {
        int            due;
        logic [3:0]    oh;
        logic [DW-1:0] data;
    } exp_t;

    function automatic vec_t mk(input logic fs, input logic [3:0] rq, input logic [3:0] g,
                                input logic rd, input logic [AW-1:0] ra, input logic bz);
        vec_t v;
        v.fs = fs; v.rq = rq; v.g = g; v.rd = rd; v.ra = ra; v.bz = bz;
        return v;
    endfunction

    vec_t       vt [38];
    exp_t       sq [$];
    exp_t       e;
    logic [2:0] exp3 [4];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req_v);
        end
    endtask

    task automatic monitor();
        if (sq.size() > 0 && sq[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(sq[0].oh));
            chk("rsp_data", 32'(rsp_data), 32'(sq[0].data));
            void'(sq.pop_front());
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_rom_rd"}, 32'(rom_rd), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        //           fs    req      gnt      rd    raddr busy
        vt[0]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, '0, 1'b0);
        vt[1]  = mk(1'b0, 4'b0010, 4'b0010, 1'b0, '0, 1'b0);
        vt[2]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, A1, 1'b1);
        vt[3]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A1, 1'b1);
        vt[4]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A1, 1'b1);
        vt[5]  = mk(1'b0, 4'b0011, 4'b0001, 1'b0, A1, 1'b0);
        vt[6]  = mk(1'b0, 4'b1111, 4'b0010, 1'b1, A0, 1'b1);
        vt[7]  = mk(1'b0, 4'b1111, 4'b0100, 1'b1, A1, 1'b1);
        vt[8]  = mk(1'b0, 4'b1111, 4'b1000, 1'b1, A2, 1'b1);
        vt[9]  = mk(1'b0, 4'b1111, 4'b0001, 1'b1, A3, 1'b1);
        vt[10] = mk(1'b0, 4'b1111, 4'b0010, 1'b1, A0, 1'b1);
        vt[11] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, A1, 1'b1);
        vt[12] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A1, 1'b1);
        vt[13] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A1, 1'b1);
        vt[14] = mk(1'b0, 4'b0100, 4'b0100, 1'b0, A1, 1'b0);
        vt[15] = mk(1'b0, 4'b0100, 4'b0100, 1'b1, A2, 1'b1);
        vt[16] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, A2, 1'b1);
        vt[17] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A2, 1'b1);
        vt[18] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A2, 1'b1);
        vt[19] = mk(1'b0, 4'b0010, 4'b0010, 1'b0, A2, 1'b0);
        vt[20] = mk(1'b1, 4'b0100, 4'b0100, 1'b1, A1, 1'b1);
        vt[21] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, A2, 1'b1);
        vt[22] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, A2, 1'b1);
        vt[23] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, A2, 1'b1);
        vt[24] = mk(1'b0, 4'b1111, 4'b0001, 1'b0, A2, 1'b0);
        vt[25] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, A0, 1'b1);
        vt[26] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b1);
        vt[27] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b1);
        vt[28] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, A0, 1'b0);
        vt[29] = mk(1'b1, 4'b0001, 4'b0000, 1'b0, A0, 1'b1);
        vt[30] = mk(1'b0, 4'b0001, 4'b0000, 1'b0, A0, 1'b1);
        vt[31] = mk(1'b0, 4'b0001, 4'b0000, 1'b0, A0, 1'b1);
        vt[32] = mk(1'b0, 4'b0001, 4'b0000, 1'b0, A0, 1'b1);
        vt[33] = mk(1'b0, 4'b0001, 4'b0001, 1'b0, A0, 1'b0);
        vt[34] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, A0, 1'b1);
        vt[35] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b1);
        vt[36] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b1);
        vt[37] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, A0, 1'b0);
        exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;

        Reset      = 1'b1;
        frame_sync = 1'b0;
        fs3        = 1'b0;
        req        = '0;
        req3       = '0;
        req_addr   = {A3, A2, A1, A0};
        req_addr3  = {B2, B1, B0};

        @(negedge clk);
        chk_reset_outputs("init");
        @(posedge clk);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        cyc   = 0;

        for (int i = 0; i < 38; i++) begin
            frame_sync = vt[i].fs;
            req        = vt[i].rq;
            @(negedge clk);
            chk("gnt", 32'(gnt), 32'(vt[i].g));
            chk("rom_rd", 32'(rom_rd), 32'(vt[i].rd));
            chk("rom_addr", 32'(rom_addr), 32'(vt[i].ra));
            chk("busy", 32'(busy), 32'(vt[i].bz));
            if (vt[i].g != 4'b0000) begin
                e.due  = cyc + 3;
                e.oh   = vt[i].g;
                e.data = romf(addr_of(vt[i].g));
                sq.push_back(e);
            end
            monitor();
            @(posedge clk);
            cyc++;
            #1;
        end
        frame_sync = 1'b0;
        req        = '0;

        // Reset one cycle after an acceptance: the read must vanish
        req = 4'b0001;
        @(negedge clk);
        chk("rst_seq_gnt", 32'(gnt), 32'b0001);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        req = 4'b0000;
        @(negedge clk);
        chk("rst_seq_rd", 32'(rom_rd), 32'd1);
        chk("rst_seq_busy", 32'(busy), 32'd1);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        Reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid");
        @(posedge clk);
        cyc++;
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
        end

        // Three-requester instance: grant order 0,1,2,0 and matching returns
        for (int k = 0; k < 8; k++) begin
            req3 = (k < 4) ? 3'b111 : 3'b000;
            @(negedge clk);
            if (k < 4) chk("gnt3", 32'(gnt3), 32'(exp3[k]));
            else       chk("gnt3_idle", 32'(gnt3), 32'd0);
            if (k >= 3 && k < 7) begin
                chk("rsp3_valid", 32'(rsp_valid3), 32'(exp3[k-3]));
                chk("rsp3_data", 32'(rsp_data3), 32'(romf(addr3_of(exp3[k-3]))));
            end else begin
                chk("rsp3_idle", 32'(rsp_valid3), 32'd0);
            end
            monitor();
            @(posedge clk);
            cyc++;
            #1;
        end

        chk("sb_empty", 32'(sq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
